// File: rtl/nf10_upb_packet_fifo_ext.sv
// Packet FIFO: commit/revert writes, overflow poisoning, FWFT packet reads with DROP.
// Define NF10_UPB_PACKET_FIFO_LEN_EN to store per-packet lengths and expose them on LEN.
module nf10_upb_packet_fifo_ext #(
    parameter int DATA_WIDTH     = 64,
    parameter int METADATA_WIDTH = 16,
    parameter int DATA_DEPTH     = 10,
    parameter int METADATA_DEPTH = 5,
    parameter int LOW_THRESHOLD  = 16,
    parameter int HIGH_THRESHOLD = 768
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [DATA_WIDTH-1:0]     DI,
    input  logic [METADATA_WIDTH-1:0] MI,
    input  logic                      WREN,
    input  logic                      COMMIT,
    input  logic                      REVERT,
    input  logic                      RDEN,
    input  logic                      DROP,
    output logic [DATA_WIDTH-1:0]     DO,
    output logic [METADATA_WIDTH-1:0] MO,
    output logic                      EOP,
    output logic                      EMPTY,
    output logic                      FULL,
    output logic                      RDERR,
    output logic                      WRERR,
    output logic                      DROPPED,
    output logic [METADATA_DEPTH:0]   PKT_COUNT,
    output logic                      BELOW_LOW,
`ifdef NF10_UPB_PACKET_FIFO_LEN_EN
    output logic [DATA_DEPTH:0]       LEN,
`endif
    output logic                      ABOVE_HIGH
);

    localparam int RAM_WORDS  = 1 << DATA_DEPTH;
    localparam int DESC_WORDS = 1 << METADATA_DEPTH;
    localparam logic [DATA_DEPTH:0]     DPTR_ONE  = {{DATA_DEPTH{1'b0}}, 1'b1};
    localparam logic [DATA_DEPTH:0]     DPTR_FULL = {1'b1, {DATA_DEPTH{1'b0}}};
    localparam logic [METADATA_DEPTH:0] MPTR_ONE  = {{METADATA_DEPTH{1'b0}}, 1'b1};
    localparam logic [METADATA_DEPTH:0] MPTR_FULL = {1'b1, {METADATA_DEPTH{1'b0}}};
    localparam logic BELOW_LOW_RST = (LOW_THRESHOLD > 0);

    logic [DATA_WIDTH-1:0]     ram_q       [RAM_WORDS];
    logic [METADATA_WIDTH-1:0] desc_meta_q [DESC_WORDS];
    logic [DATA_DEPTH:0]       desc_end_q  [DESC_WORDS];
`ifdef NF10_UPB_PACKET_FIFO_LEN_EN
    logic [DATA_DEPTH:0]       desc_len_q  [DESC_WORDS];
    logic [DATA_DEPTH:0]       len_q, len_d;
`endif

    logic [DATA_DEPTH:0]       wr_ptr_q, wr_ptr_d;
    logic [DATA_DEPTH:0]       commit_ptr_q, commit_ptr_d;
    logic [DATA_DEPTH:0]       rd_ptr_q, rd_ptr_d;
    logic [METADATA_DEPTH:0]   desc_wr_q, desc_wr_d;
    logic [METADATA_DEPTH:0]   desc_rd_q, desc_rd_d;
    logic                      poison_q, poison_d;
    logic                      out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]     do_q, do_d;
    logic [METADATA_WIDTH-1:0] mo_q, mo_d;
    logic                      eop_q, eop_d;
    logic                      rderr_q, rderr_d;
    logic                      wrerr_q, wrerr_d;
    logic                      dropped_q, dropped_d;
    logic                      below_low_q, below_low_d;
    logic                      above_high_q, above_high_d;

    logic                      ram_we;
    logic                      desc_we;
    logic                      full;
    logic [DATA_DEPTH:0]       used_q;
    logic [DATA_DEPTH:0]       used_d;
    logic [31:0]               used_d_ext;
    logic [METADATA_DEPTH:0]   desc_cnt;
    logic [DATA_DEPTH:0]       head_end;
    logic [METADATA_DEPTH-1:0] next_desc;

    // Occupancy counts every written word, committed or not, including the presented head.
    assign used_q   = wr_ptr_q - rd_ptr_q;
    assign desc_cnt = desc_wr_q - desc_rd_q;
    assign full     = (used_q == DPTR_FULL) || (desc_cnt == MPTR_FULL);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        desc_wr_d    = desc_wr_q;
        poison_d     = poison_q;
        wrerr_d      = 1'b0;
        dropped_d    = 1'b0;
        ram_we       = 1'b0;
        desc_we      = 1'b0;
        if (REVERT) begin
            wr_ptr_d = commit_ptr_q;
            poison_d = 1'b0;
            wrerr_d  = COMMIT;
        end else if (COMMIT && !WREN) begin
            wrerr_d = 1'b1;
        end else if (WREN) begin
            if (poison_q) begin
                if (COMMIT) begin
                    wr_ptr_d  = commit_ptr_q;
                    poison_d  = 1'b0;
                    dropped_d = 1'b1;
                end
            end else if (full) begin
                // An overflowing last word cannot be stored, so its packet is discarded at once.
                wrerr_d = 1'b1;
                if (COMMIT) begin
                    wr_ptr_d  = commit_ptr_q;
                    dropped_d = 1'b1;
                end else begin
                    poison_d = 1'b1;
                end
            end else begin
                ram_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + DPTR_ONE;
                if (COMMIT) begin
                    desc_we      = 1'b1;
                    desc_wr_d    = desc_wr_q + MPTR_ONE;
                    commit_ptr_d = wr_ptr_q + DPTR_ONE;
                end
            end
        end
    end

    assign head_end = desc_end_q[desc_rd_q[METADATA_DEPTH-1:0]];

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        desc_rd_d = desc_rd_q;
        rderr_d   = 1'b0;
        if (DROP || RDEN) begin
            if (!out_valid_q) begin
                rderr_d = 1'b1;
            end else if (DROP) begin
                rd_ptr_d  = head_end + DPTR_ONE;
                desc_rd_d = desc_rd_q + MPTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q + DPTR_ONE;
                if (eop_q) begin
                    desc_rd_d = desc_rd_q + MPTR_ONE;
                end
            end
        end
    end

    // Comparing against the registered commit pointer delays new packets by one edge, and
    // guarantees the addressed RAM word is never the one being written this cycle.
    assign next_desc = desc_rd_d[METADATA_DEPTH-1:0];

    always_comb begin
        out_valid_d = (rd_ptr_d != commit_ptr_q);
        do_d        = '0;
        mo_d        = '0;
        eop_d       = 1'b0;
`ifdef NF10_UPB_PACKET_FIFO_LEN_EN
        len_d       = '0;
`endif
        if (out_valid_d) begin
            do_d  = ram_q[rd_ptr_d[DATA_DEPTH-1:0]];
            mo_d  = desc_meta_q[next_desc];
            eop_d = (rd_ptr_d == desc_end_q[next_desc]);
`ifdef NF10_UPB_PACKET_FIFO_LEN_EN
            len_d = desc_len_q[next_desc];
`endif
        end
    end

    assign used_d       = wr_ptr_d - rd_ptr_d;
    assign used_d_ext   = 32'(used_d);
    assign below_low_d  = (used_d_ext < LOW_THRESHOLD);
    assign above_high_d = (used_d_ext > HIGH_THRESHOLD);

    always_ff @(posedge CLK) begin
        if (ram_we) begin
            ram_q[wr_ptr_q[DATA_DEPTH-1:0]] <= DI;
        end
    end

    always_ff @(posedge CLK) begin
        if (desc_we) begin
            desc_meta_q[desc_wr_q[METADATA_DEPTH-1:0]] <= MI;
            desc_end_q[desc_wr_q[METADATA_DEPTH-1:0]]  <= wr_ptr_q;
`ifdef NF10_UPB_PACKET_FIFO_LEN_EN
            desc_len_q[desc_wr_q[METADATA_DEPTH-1:0]]  <= wr_ptr_q + DPTR_ONE - commit_ptr_q;
`endif
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            desc_wr_q    <= '0;
            desc_rd_q    <= '0;
            poison_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            do_q         <= '0;
            mo_q         <= '0;
            eop_q        <= 1'b0;
            rderr_q      <= 1'b0;
            wrerr_q      <= 1'b0;
            dropped_q    <= 1'b0;
            below_low_q  <= BELOW_LOW_RST;
            above_high_q <= 1'b0;
`ifdef NF10_UPB_PACKET_FIFO_LEN_EN
            len_q        <= '0;
`endif
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            desc_wr_q    <= desc_wr_d;
            desc_rd_q    <= desc_rd_d;
            poison_q     <= poison_d;
            out_valid_q  <= out_valid_d;
            do_q         <= do_d;
            mo_q         <= mo_d;
            eop_q        <= eop_d;
            rderr_q      <= rderr_d;
            wrerr_q      <= wrerr_d;
            dropped_q    <= dropped_d;
            below_low_q  <= below_low_d;
            above_high_q <= above_high_d;
`ifdef NF10_UPB_PACKET_FIFO_LEN_EN
            len_q        <= len_d;
`endif
        end
    end

    assign DO         = do_q;
    assign MO         = mo_q;
    assign EOP        = eop_q;
    assign EMPTY      = !out_valid_q;
    assign FULL       = full;
    assign RDERR      = rderr_q;
    assign WRERR      = wrerr_q;
    assign DROPPED    = dropped_q;
    assign PKT_COUNT  = desc_cnt;
    assign BELOW_LOW  = below_low_q;
    assign ABOVE_HIGH = above_high_q;
`ifdef NF10_UPB_PACKET_FIFO_LEN_EN
    assign LEN        = len_q;
`endif

endmodule

// File: tb/tb_nf10_upb_packet_fifo_ext.sv
// Directed bench for nf10_upb_packet_fifo_ext: a default-size instance and a small
// instance (8 words, 4 descriptors) share the same stimulus.
module tb_nf10_upb_packet_fifo_ext;

    logic        clk;
    logic        rst_n;
    logic [63:0] di;
    logic [15:0] mi;
    logic        wren, commit, revert, rden, drop;

    logic [63:0] a_do, b_do;
    logic [15:0] a_mo, b_mo;
    logic        a_eop, a_empty, a_full, a_rderr, a_wrerr, a_dropped, a_below_low, a_above_high;
    logic        b_eop, b_empty, b_full, b_rderr, b_wrerr, b_dropped, b_below_low, b_above_high;
    logic [5:0]  a_pkt_count;
    logic [2:0]  b_pkt_count;
`ifdef NF10_UPB_PACKET_FIFO_LEN_EN
    logic [10:0] a_len;
    logic [3:0]  b_len;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q[$];

    nf10_upb_packet_fifo_ext dut_a (
        .CLK(clk), .RST_N(rst_n), .DI(di), .MI(mi), .WREN(wren), .COMMIT(commit),
        .REVERT(revert), .RDEN(rden), .DROP(drop), .DO(a_do), .MO(a_mo), .EOP(a_eop),
        .EMPTY(a_empty), .FULL(a_full), .RDERR(a_rderr), .WRERR(a_wrerr), .DROPPED(a_dropped),
        .PKT_COUNT(a_pkt_count), .BELOW_LOW(a_below_low),
`ifdef NF10_UPB_PACKET_FIFO_LEN_EN
        .LEN(a_len),
`endif
        .ABOVE_HIGH(a_above_high)
    );

    nf10_upb_packet_fifo_ext #(
        .DATA_WIDTH(64), .METADATA_WIDTH(16), .DATA_DEPTH(3), .METADATA_DEPTH(2),
        .LOW_THRESHOLD(2), .HIGH_THRESHOLD(4)
    ) dut_b (
        .CLK(clk), .RST_N(rst_n), .DI(di), .MI(mi), .WREN(wren), .COMMIT(commit),
        .REVERT(revert), .RDEN(rden), .DROP(drop), .DO(b_do), .MO(b_mo), .EOP(b_eop),
        .EMPTY(b_empty), .FULL(b_full), .RDERR(b_rderr), .WRERR(b_wrerr), .DROPPED(b_dropped),
        .PKT_COUNT(b_pkt_count), .BELOW_LOW(b_below_low),
`ifdef NF10_UPB_PACKET_FIFO_LEN_EN
        .LEN(b_len),
`endif
        .ABOVE_HIGH(b_above_high)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        wren   = 1'b0;
        commit = 1'b0;
        revert = 1'b0;
        rden   = 1'b0;
        drop   = 1'b0;
    endtask

    task automatic do_reset();
        clear_in();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        clear_in();
        di    = '0;
        mi    = '0;
        rst_n = 1'b0;
        step();
        step();

        // reset values
        check("rst_empty",      64'(a_empty), 64'd1);
        check("rst_full",       64'(a_full), 64'd0);
        check("rst_eop",        64'(a_eop), 64'd0);
        check("rst_do",         a_do, 64'd0);
        check("rst_mo",         64'(a_mo), 64'd0);
        check("rst_rderr",      64'(a_rderr), 64'd0);
        check("rst_wrerr",      64'(a_wrerr), 64'd0);
        check("rst_dropped",    64'(a_dropped), 64'd0);
        check("rst_pkt_count",  64'(a_pkt_count), 64'd0);
        check("rst_below_low",  64'(a_below_low), 64'd1);
        check("rst_above_high", 64'(a_above_high), 64'd0);
        check("rst_b_below",    64'(b_below_low), 64'd1);
        rst_n = 1'b1;

        // packet write and FWFT read
        exp_q.push_back(64'hdeadbeef);
        exp_q.push_back(64'haffedeaf);
        wren = 1'b1; di = 64'hdeadbeef; step();
        commit = 1'b1; mi = 16'h55; di = 64'haffedeaf; step();
        clear_in();
        check("p1_empty_commit_edge", 64'(a_empty), 64'd1);
        check("p1_pkt_count",         64'(a_pkt_count), 64'd1);
        step();
        check("p1_empty",   64'(a_empty), 64'd0);
        check("p1_do0",     a_do, exp_q.pop_front());
        check("p1_mo",      64'(a_mo), 64'h55);
        check("p1_eop0",    64'(a_eop), 64'd0);
`ifdef NF10_UPB_PACKET_FIFO_LEN_EN
        check("p1_len",     64'(a_len), 64'd2);
`endif
        rden = 1'b1; step();
        check("p1_do1",     a_do, exp_q.pop_front());
        check("p1_eop1",    64'(a_eop), 64'd1);
        check("p1_mo1",     64'(a_mo), 64'h55);
        step();
        rden = 1'b0;
        check("p1_empty_after", 64'(a_empty), 64'd1);
        check("p1_pkt_after",   64'(a_pkt_count), 64'd0);

        // revert
        for (int i = 0; i < 5; i++) begin
            wren = 1'b1; di = 64'(32'h200 + i); step();
        end
        check("p2_a_below_5w",  64'(a_below_low), 64'd1);
        check("p2_b_below_5w",  64'(b_below_low), 64'd0);
        check("p2_b_above_5w",  64'(b_above_high), 64'd1);
        check("p2_empty_5w",    64'(a_empty), 64'd1);
        revert = 1'b1; di = 64'h2ff; step();
        clear_in();
        check("p2_empty_rev",   64'(a_empty), 64'd1);
        check("p2_a_below_rev", 64'(a_below_low), 64'd1);
        check("p2_b_below_rev", 64'(b_below_low), 64'd1);
        check("p2_b_above_rev", 64'(b_above_high), 64'd0);
        wren = 1'b1; commit = 1'b1; di = 64'h1234; mi = 16'h77; step();
        clear_in();
        step();
        check("p2_rewind_do",  a_do, 64'h1234);
        check("p2_rewind_eop", 64'(a_eop), 64'd1);
        check("p2_rewind_mo",  64'(a_mo), 64'h77);
`ifdef NF10_UPB_PACKET_FIFO_LEN_EN
        check("p2_rewind_len", 64'(a_len), 64'd1);
`endif
        rden = 1'b1; step(); rden = 1'b0;
        check("p2_popped_empty", 64'(a_empty), 64'd1);

        // overflow poisoning on the 8-word instance
        for (int i = 1; i <= 11; i++) begin
            wren = 1'b1; commit = (i == 11); di = 64'(32'h300 + i); mi = 16'h99; step();
            if (i == 8) check("p3_full_w8", 64'(b_full), 64'd1);
            if (i == 8) check("p3_wrerr_w8", 64'(b_wrerr), 64'd0);
            if (i == 9) check("p3_wrerr_w9", 64'(b_wrerr), 64'd1);
            if (i == 10) check("p3_wrerr_w10", 64'(b_wrerr), 64'd0);
        end
        clear_in();
        check("p3_dropped",    64'(b_dropped), 64'd1);
        check("p3_pkt_count",  64'(b_pkt_count), 64'd0);
        check("p3_full_clear", 64'(b_full), 64'd0);
        check("p3_wrerr_w11",  64'(b_wrerr), 64'd0);
        step();
        check("p3_dropped_end", 64'(b_dropped), 64'd0);
        check("p3_empty",       64'(b_empty), 64'd1);
        do_reset();

        // descriptor FIFO full on the 4-descriptor instance
        for (int i = 0; i < 4; i++) begin
            wren = 1'b1; commit = 1'b1; di = 64'(32'h400 + i); mi = 16'(32'h40 + i); step();
        end
        clear_in();
        check("p4_b_pkt_count", 64'(b_pkt_count), 64'd4);
        check("p4_b_full",      64'(b_full), 64'd1);
        check("p4_a_full",      64'(a_full), 64'd0);
        check("p4_a_pkt_count", 64'(a_pkt_count), 64'd4);
        wren = 1'b1; di = 64'h4ff; step();
        clear_in();
        check("p4_wrerr",    64'(b_wrerr), 64'd1);
        check("p4_head_do",  b_do, 64'h400);
        check("p4_head_mo",  64'(b_mo), 64'h40);
        check("p4_head_eop", 64'(b_eop), 64'd1);
`ifdef NF10_UPB_PACKET_FIFO_LEN_EN
        check("p4_head_len", 64'(b_len), 64'd1);
`endif
        revert = 1'b1; step();
        clear_in();
        check("p4_revert_wrerr", 64'(b_wrerr), 64'd0);
        do_reset();

        // DROP of a partly read head packet
        for (int i = 0; i < 3; i++) begin
            wren = 1'b1; commit = (i == 2); di = 64'(32'ha0 + i); mi = 16'h11; step();
        end
        for (int i = 0; i < 2; i++) begin
            wren = 1'b1; commit = (i == 1); di = 64'(32'hb0 + i); mi = 16'h22; step();
        end
        clear_in();
        rden = 1'b1; step(); rden = 1'b0;
        check("p5_do_a1",   a_do, 64'ha1);
        check("p5_mo_a",    64'(a_mo), 64'h11);
        check("p5_eop_a1",  64'(a_eop), 64'd0);
        check("p5_pkt_2",   64'(a_pkt_count), 64'd2);
        drop = 1'b1; step(); drop = 1'b0;
        check("p5_drop_do",  a_do, 64'hb0);
        check("p5_drop_mo",  64'(a_mo), 64'h22);
        check("p5_drop_eop", 64'(a_eop), 64'd0);
        check("p5_drop_pkt", 64'(a_pkt_count), 64'd1);
        check("p5_drop_emp", 64'(a_empty), 64'd0);
`ifdef NF10_UPB_PACKET_FIFO_LEN_EN
        check("p5_drop_len", 64'(a_len), 64'd2);
`endif
        drop = 1'b1; rden = 1'b1; step();
        clear_in();
        check("p5_prio_empty", 64'(a_empty), 64'd1);
        check("p5_prio_pkt",   64'(a_pkt_count), 64'd0);
        check("p5_prio_rderr", 64'(a_rderr), 64'd0);
        drop = 1'b1; step(); drop = 1'b0;
        check("p5_rderr",       64'(a_rderr), 64'd1);
        check("p5_rderr_empty", 64'(a_empty), 64'd1);
        step();
        check("p5_rderr_pulse", 64'(a_rderr), 64'd0);

        // asynchronous reset in the middle of a packet
        wren = 1'b1; commit = 1'b1; di = 64'h600; mi = 16'h66; step();
        commit = 1'b0;
        for (int i = 1; i < 8; i++) begin
            di = 64'(32'h600 + i); step();
        end
        check("p6_b_full_pre", 64'(b_full), 64'd1);
        check("p6_a_empty_pre", 64'(a_empty), 64'd0);
        check("p6_a_pkt_pre",  64'(a_pkt_count), 64'd1);
`ifdef NF10_UPB_PACKET_FIFO_LEN_EN
        check("p6_a_len_pre",  64'(a_len), 64'd1);
`endif
        #2 rst_n = 1'b0;
        #1;
        check("p6_a_empty",  64'(a_empty), 64'd1);
        check("p6_a_pkt",    64'(a_pkt_count), 64'd0);
        check("p6_a_full",   64'(a_full), 64'd0);
        check("p6_b_full",   64'(b_full), 64'd0);
        check("p6_b_pkt",    64'(b_pkt_count), 64'd0);
        check("p6_b_empty",  64'(b_empty), 64'd1);
`ifdef NF10_UPB_PACKET_FIFO_LEN_EN
        check("p6_a_len",    64'(a_len), 64'd0);
`endif
        clear_in();
        step();
        rst_n = 1'b1;
        step();

        // final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
